vga_config_master: RTL and testbench

Initiator side of the VGA configuration write port: turns two pushbuttons (next/previous resolution) into single-cycle `Valid`/`Addr`/`Data` writes to the VGA config register block. Writes are aligned to frame boundaries, acknowledged via the config block's `Load_config`, and retried on timeout. A boot write of the default mode is issued after every reset. The block sits between the board I/O and the VGA config block, alongside the timing generator that supplies `Frame_start`.

---
 rtl/vga_config_master.sv | 198 +++++++++++++++++++
 tb/tb_vga_config_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_config_master.sv
// ============================================================================
// Module   : vga_config_master
// Purpose  : Pushbutton-driven resolution writes to the VGA config block,
//            frame-aligned, acknowledged, with timeout and retry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_config_master #(
    parameter int                      CONFIG_WIDTH    = 4,
    parameter logic [CONFIG_WIDTH-1:0] CONFIG_ADDR     = 4'b1011,
    parameter int                      NUM_MODES       = 3,
    parameter int                      MODE_WIDTH      = 2,
    parameter int                      DEBOUNCE_CYCLES = 16,
    parameter int                      ACK_TIMEOUT     = 8,
    parameter int                      MAX_RETRY       = 2
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Btn_next,
    input  logic                    Btn_prev,
    input  logic                    Frame_start,
    input  logic                    Load_config,
    output logic                    Valid,
    output logic [CONFIG_WIDTH-1:0] Addr,
    output logic [CONFIG_WIDTH-1:0] Data,
    output logic [MODE_WIDTH-1:0]   Mode,
    output logic                    Busy,
    output logic                    Error
);

    localparam int c_DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int c_RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [c_DB_W-1:0]     c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_ACK_W-1:0]    c_ACK_LAST  = c_ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [c_RTY_W-1:0]    c_RTY_MAX   = c_RTY_W'(MAX_RETRY);
    localparam logic [MODE_WIDTH-1:0] c_MODE_LAST = MODE_WIDTH'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FRAME = 2'd1,
        S_SEND       = 2'd2,
        S_WAIT_ACK   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Button conditioning: bit 0 = next, bit 1 = prev
    // ------------------------------------------------------------------
    logic [1:0] w_btn_raw;
    logic [1:0] w_press;

    assign w_btn_raw = {Btn_prev, Btn_next};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic [1:0]        r_sync;
        logic              r_stable;
        logic [c_DB_W-1:0] r_cnt;
        logic              w_settled;

        // Synced level has differed from the stable level long enough to accept it.
        assign w_settled   = (r_sync[1] != r_stable) && (r_cnt == c_DB_LAST);
        assign w_press[gi] = w_settled & r_sync[1];

        always_ff @(posedge Clk) begin
            if (Rst) begin
                r_sync   <= 2'b00;
                r_stable <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_sync <= {r_sync[0], w_btn_raw[gi]};
                if (r_sync[1] == r_stable) begin
                    r_cnt <= '0;
                end else if (w_settled) begin
                    r_stable <= r_sync[1];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + c_DB_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Write-request FSM
    // ------------------------------------------------------------------
    state_t                  r_state, w_state_next;
    logic                    r_boot;
    logic [MODE_WIDTH-1:0]   r_pending, w_pending_next;
    logic [MODE_WIDTH-1:0]   r_mode, w_mode_next;
    logic [c_RTY_W-1:0]      r_retry, w_retry_next;
    logic [c_ACK_W-1:0]      r_ack_cnt, w_ack_cnt_next;
    logic                    w_error_next;
    logic [MODE_WIDTH-1:0]   w_mode_inc;
    logic [MODE_WIDTH-1:0]   w_mode_dec;
    logic                    r_valid;
    logic                    r_busy;
    logic                    r_error;
    logic [CONFIG_WIDTH-1:0] r_addr;
    logic [CONFIG_WIDTH-1:0] r_data;

    assign w_mode_inc = (r_mode == c_MODE_LAST) ? '0 : r_mode + MODE_WIDTH'(1);
    assign w_mode_dec = (r_mode == '0) ? c_MODE_LAST : r_mode - MODE_WIDTH'(1);

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_mode_next    = r_mode;
        w_retry_next   = r_retry;
        w_ack_cnt_next = r_ack_cnt;
        w_error_next   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // The boot write takes priority over any button activity.
                if (r_boot) begin
                    w_state_next   = S_WAIT_FRAME;
                    w_pending_next = '0;
                    w_retry_next   = '0;
                end else if (w_press[0] ^ w_press[1]) begin
                    w_state_next   = S_WAIT_FRAME;
                    w_pending_next = w_press[0] ? w_mode_inc : w_mode_dec;
                    w_retry_next   = '0;
                end
            end
            S_WAIT_FRAME: begin
                if (Frame_start) begin
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                w_state_next   = S_WAIT_ACK;
                w_ack_cnt_next = '0;
            end
            S_WAIT_ACK: begin
                if (Load_config) begin
                    w_mode_next  = r_pending;
                    w_state_next = S_IDLE;
                end else if (r_ack_cnt == c_ACK_LAST) begin
                    if (r_retry < c_RTY_MAX) begin
                        w_retry_next = r_retry + c_RTY_W'(1);
                        w_state_next = S_WAIT_FRAME;
                    end else begin
                        w_error_next = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_ack_cnt_next = r_ack_cnt + c_ACK_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they align with r_state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_boot    <= 1'b1;
            r_pending <= '0;
            r_mode    <= '0;
            r_retry   <= '0;
            r_ack_cnt <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_error   <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_boot    <= 1'b0;
            r_pending <= w_pending_next;
            r_mode    <= w_mode_next;
            r_retry   <= w_retry_next;
            r_ack_cnt <= w_ack_cnt_next;
            r_valid   <= (w_state_next == S_SEND);
            r_busy    <= (w_state_next != S_IDLE);
            r_error   <= w_error_next;
            if (w_state_next == S_SEND) begin
                r_addr <= CONFIG_ADDR;
                r_data <= CONFIG_WIDTH'(r_pending);
            end
        end
    end

    assign Valid = r_valid;
    assign Addr  = r_addr;
    assign Data  = r_data;
    assign Mode  = r_mode;
    assign Busy  = r_busy;
    assign Error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_vga_config_master.sv
// ============================================================================
// Module   : tb_vga_config_master
// Purpose  : Randomized scoreboard bench for vga_config_master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_config_master;

    localparam int             CW    = 4;
    localparam logic [CW-1:0]  CADDR = 4'b1011;
    localparam int             NM    = 3;
    localparam int             MW    = 2;
    localparam int             DB    = 16;
    localparam int             AT    = 8;
    localparam int             MR    = 2;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          Btn_next = 1'b0;
    logic          Btn_prev = 1'b0;
    logic          Frame_start = 1'b0;
    logic          Load_config = 1'b0;
    logic          Valid;
    logic [CW-1:0] Addr;
    logic [CW-1:0] Data;
    logic [MW-1:0] Mode;
    logic          Busy;
    logic          Error;

    vga_config_master #(
        .CONFIG_WIDTH    (CW),
        .CONFIG_ADDR     (CADDR),
        .NUM_MODES       (NM),
        .MODE_WIDTH      (MW),
        .DEBOUNCE_CYCLES (DB),
        .ACK_TIMEOUT     (AT),
        .MAX_RETRY       (MR)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Btn_next    (Btn_next),
        .Btn_prev    (Btn_prev),
        .Frame_start (Frame_start),
        .Load_config (Load_config),
        .Valid       (Valid),
        .Addr        (Addr),
        .Data        (Data),
        .Mode        (Mode),
        .Busy        (Busy),
        .Error       (Error)
    );

    always #5 Clk = ~Clk;

    int            n_tests    = 0;
    int            n_fail     = 0;
    int            m_mode     = 0;
    int            exp_errors = 0;
    int            seen_errors = 0;
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] mon_exp;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge Clk) begin
        if (Error) seen_errors++;
        if (Valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("write_addr", int'(Addr), int'(CADDR));
                check("write_data", int'(Data), int'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_busy(input logic v, input string name);
        for (int i = 0; i < 40; i++) begin
            if (Busy == v) break;
            tick();
        end
        check(name, int'(Busy), int'(v));
    endtask

    // Drives frames/acks for one request; the DUT must already be in WAIT_FRAME.
    task automatic run_request(input int pend, input bit no_ack);
        int ack;
        bit stray;
        for (int a = 0; a <= MR; a++) begin
            int gap;
            gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 3) == 0) Load_config = 1'b1;
                tick();
                Load_config = 1'b0;
            end
            Frame_start = 1'b1;
            exp_q.push_back(CW'(pend));
            tick();
            Frame_start = 1'b0;
            ack   = (!no_ack && $urandom_range(0, 2) != 0) ? int'($urandom_range(1, AT)) : 0;
            stray = 1'($urandom_range(0, 1));
            tick();
            for (int k = 1; k <= AT; k++) begin
                if (k == 1 && stray) Frame_start = 1'b1;
                if (k == ack) Load_config = 1'b1;
                tick();
                Frame_start = 1'b0;
                Load_config = 1'b0;
                if (k == ack) break;
            end
            if (ack != 0) begin
                m_mode = pend;
                check("mode_after_ack", int'(Mode), m_mode);
                check("busy_after_ack", int'(Busy), 0);
                check("no_error_on_ack", int'(Error), 0);
                return;
            end
            if (a == MR) begin
                exp_errors++;
                check("error_pulse", int'(Error), 1);
                check("busy_after_error", int'(Busy), 0);
                check("mode_kept_on_error", int'(Mode), m_mode);
            end else begin
                check("busy_on_retry", int'(Busy), 1);
                check("no_error_on_retry", int'(Error), 0);
            end
        end
    endtask

    function automatic int step(input int m, input bit nxt);
        return nxt ? (m + 1) % NM : (m + NM - 1) % NM;
    endfunction

    task automatic press(input bit nxt, input bit prv, input bit busy_press, input bit no_ack);
        int pend;
        Btn_next = nxt;
        Btn_prev = prv;
        if (nxt ^ prv) begin
            pend = step(m_mode, nxt);
            wait_busy(1'b1, "press_accepted");
            Btn_next = 1'b0;
            Btn_prev = 1'b0;
            repeat (20) tick();
            if (busy_press) begin
                Btn_next = prv;
                Btn_prev = nxt;
                repeat (22) tick();
                Btn_next = 1'b0;
                Btn_prev = 1'b0;
                repeat (20) tick();
            end
            run_request(pend, no_ack);
        end else begin
            repeat (25) tick();
            check("simul_press_idle", int'(Busy), 0);
            Btn_next = 1'b0;
            Btn_prev = 1'b0;
            repeat (20) tick();
            check("simul_release_idle", int'(Busy), 0);
        end
    endtask

    task automatic boot();
        Rst = 1'b0;
        tick();
        check("boot_busy", int'(Busy), 1);
        m_mode = 0;
        run_request(0, 1'b0);
        m_mode = int'(Mode);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        Rst = 1'b1;
        repeat (4) tick();
        check("rst_valid", int'(Valid), 0);
        check("rst_addr", int'(Addr), 0);
        check("rst_data", int'(Data), 0);
        check("rst_mode", int'(Mode), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_error", int'(Error), 0);
        boot();
        // A boot write that timed out leaves Mode at 0 as well.
        m_mode = 0;

        // Bouncing prev from mode 0 must produce exactly one wrap-around write.
        for (int i = 0; i < 4; i++) begin
            Btn_prev = ~Btn_prev;
            repeat (3) tick();
        end
        Btn_prev = 1'b1;
        wait_busy(1'b1, "bounce_accepted");
        Btn_prev = 1'b0;
        repeat (20) tick();
        run_request(step(m_mode, 1'b0), 1'b0);

        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b1, 1'b0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            int op;
            op = $urandom_range(0, 5);
            case (op)
                0: press(1'b1, 1'b0, 1'b0, 1'b0);
                1: press(1'b0, 1'b1, 1'b0, 1'b0);
                2: press(1'b1, 1'b1, 1'b0, 1'b0);
                3: press(1'b1, 1'b0, 1'b1, 1'b0);
                4: press(1'b0, 1'b1, 1'b1, 1'b0);
                default: press(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
            endcase
        end

        // Reset asserted during the SEND cycle aborts the write.
        Btn_next = 1'b1;
        wait_busy(1'b1, "abort_press_accepted");
        Btn_next = 1'b0;
        repeat (20) tick();
        Frame_start = 1'b1;
        exp_q.push_back(CW'(step(m_mode, 1'b1)));
        tick();
        Frame_start = 1'b0;
        Rst = 1'b1;
        tick();
        check("abort_valid", int'(Valid), 0);
        check("abort_mode", int'(Mode), 0);
        check("abort_busy", int'(Busy), 0);
        boot();

        repeat (5) tick();
        check("queue_drained", exp_q.size(), 0);
        check("error_count", seen_errors, exp_errors);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
